// File: rtl/lsu_bus_master.sv
// lsu_bus_master
// ---------------------------------------------------------------------------
// Multi-cycle load/store unit for the rv32i core. It accepts one load or store
// from the decoder and the ALU, and runs it on a request/grant/response data bus.
// It stalls the core with busy_o until the access completes. Load results
// come back sign- or zero-extended on ld_data_o for the rd write-back mux.
//
// Ports
//   clk_i            core clock, rising-edge
//   rst_i            asynchronous active-high reset
//   en_i             access request from the decoder, held while busy_o=1
//   funct_i          LOAD / STORE
//   bytes_i          B, H, W, BU, HU (BU/HU only meaningful for loads)
//   addr_i           byte address from the ALU
//   st_data_i        rs2 data for stores
//   ld_data_o        formatted load result (registered)
//   busy_o           stall request to PC / register file (combinational)
//   misaligned_ld_o  alignment fault on a load in IDLE (combinational)
//   misaligned_st_o  alignment fault on a store in IDLE (combinational)
//   mem_req_o        bus request valid (registered)
//   mem_we_o         1 = write (registered)
//   mem_addr_o       word address, [1:0] = 0 (registered)
//   mem_be_o         byte enables (registered)
//   mem_wdata_o      lane-shifted store data (registered)
//   mem_gnt_i        request accepted this cycle
//   mem_rvalid_i     response strobe for reads and writes
//   mem_rdata_i      read data, valid with mem_rvalid_i
// ---------------------------------------------------------------------------

package lsu_bus_master_pkg;

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_funct_e;

  typedef enum logic [2:0] {
    LSU_B  = 3'd0,
    LSU_H  = 3'd1,
    LSU_W  = 3'd2,
    LSU_BU = 3'd3,
    LSU_HU = 3'd4
  } lsu_bytes_e;

endpackage

module lsu_bus_master
  import lsu_bus_master_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  lsu_funct_e  funct_i,
  input  lsu_bytes_e  bytes_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic        busy_o,
  output logic        misaligned_ld_o,
  output logic        misaligned_st_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q,     state_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [3:0]  mem_be_q,    mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] ld_data_q,   ld_data_d;
  lsu_bytes_e  bytes_q,     bytes_d;
  logic [1:0]  off_q,       off_d;

  logic [1:0]  req_off;
  logic        req_aligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        in_idle;
  logic        start;

  // Select the addressed lane of a read word and extend it to 32 bits.
  function automatic logic [31:0] fmt_load(input lsu_bytes_e b,
                                           input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] lane;
    logic [31:0] res;
    lane = rdata >> {off, 3'b000};
    case (b)
      LSU_B:   res = {{24{lane[7]}}, lane[7:0]};
      LSU_BU:  res = {24'h00_0000, lane[7:0]};
      LSU_H:   res = {{16{lane[15]}}, lane[15:0]};
      LSU_HU:  res = {16'h0000, lane[15:0]};
      LSU_W:   res = rdata;
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Decode the incoming request: alignment, byte enables and store lane shift.
  always_comb begin
    req_off     = addr_i[1:0];
    req_aligned = 1'b0;
    req_be      = 4'b0000;
    req_wdata   = st_data_i << {req_off, 3'b000};
    case (bytes_i)
      LSU_B, LSU_BU: begin
        req_aligned = 1'b1;
        req_be      = 4'b0001 << req_off;
      end
      LSU_H, LSU_HU: begin
        req_aligned = ~addr_i[0];
        req_be      = 4'b0011 << req_off;
      end
      LSU_W: begin
        req_aligned = (addr_i[1:0] == 2'b00);
        req_be      = 4'b1111;
      end
      // Unknown size codes are treated as faulting so they never reach the bus.
      default: begin
        req_aligned = 1'b0;
        req_be      = 4'b0000;
      end
    endcase
  end

  assign in_idle = (state_q == ST_IDLE);
  assign start   = in_idle & en_i & req_aligned;

  // busy covers the accepting IDLE cycle so the core stalls immediately;
  // it is low in DONE, the retirement cycle.
  assign busy_o          = start | (state_q == ST_REQ) | (state_q == ST_RESP);
  assign misaligned_ld_o = in_idle & en_i & ~req_aligned & (funct_i == LSU_LOAD);
  assign misaligned_st_o = in_idle & en_i & ~req_aligned & (funct_i == LSU_STORE);

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    ld_data_d   = ld_data_q;
    bytes_d     = bytes_q;
    off_d       = off_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = (funct_i == LSU_STORE);
          mem_addr_d  = {addr_i[31:2], 2'b00};
          mem_be_d    = req_be;
          mem_wdata_d = req_wdata;
          bytes_d     = bytes_i;
          off_d       = req_off;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_RESP: begin
        if (mem_rvalid_i) begin
          state_d = ST_DONE;
          // Write responses only complete the access; ld_data keeps the last load.
          if (!mem_we_q) begin
            ld_data_d = fmt_load(bytes_q, off_q, mem_rdata_i);
          end else begin
            ld_data_d = ld_data_q;
          end
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      ld_data_q   <= 32'h0000_0000;
      bytes_q     <= LSU_B;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      ld_data_q   <= ld_data_d;
      bytes_q     <= bytes_d;
      off_q       <= off_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign ld_data_o   = ld_data_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: a directed vector table, a reset
// mid-access sequence and a randomized run against a behavioural model.
module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  lsu_funct_e  funct;
  lsu_bytes_e  bytes;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        busy;
  logic        mis_ld;
  logic        mis_st;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_ld;

  localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

  lsu_bus_master dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .funct_i         (funct),
    .bytes_i         (bytes),
    .addr_i          (addr),
    .st_data_i       (st_data),
    .ld_data_o       (ld_data),
    .busy_o          (busy),
    .misaligned_ld_o (mis_ld),
    .misaligned_st_o (mis_st),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_be_o        (mem_be),
    .mem_wdata_o     (mem_wdata),
    .mem_gnt_i       (mem_gnt),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int m_size(input lsu_bytes_e b);
    if (b == LSU_B || b == LSU_BU) return 1;
    if (b == LSU_H || b == LSU_HU) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input lsu_bytes_e b, input logic [31:0] a);
    return (a % m_size(b)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input lsu_bytes_e b, input logic [31:0] a);
    int s = m_size(b);
    int o = int'(a % 32'd4);
    int v = ((1 << s) - 1) << o;
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [31:0] a);
    longint v = longint'(sd) << (8 * int'(a % 32'd4));
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_load(input lsu_bytes_e b, input logic [31:0] a,
                                         input logic [31:0] rd);
    int s = m_size(b);
    longint span = longint'(1) << (8 * s);
    longint lane = (longint'(rd) >> (8 * int'(a % 32'd4))) % span;
    if ((b == LSU_B || b == LSU_H) && lane >= span / 2) lane = lane - span;
    return 32'(lane);
  endfunction

  // Drive fresh unrelated inputs during busy cycles; they must be ignored.
  task automatic scramble_inputs();
    en      = 1'($urandom_range(0, 1));
    funct   = lsu_funct_e'($urandom_range(0, 1));
    bytes   = lsu_bytes_e'($urandom_range(0, 4));
    addr    = $urandom;
    st_data = $urandom;
  endtask

  // One aligned access on a fixed expected timeline.
  task automatic do_access(input lsu_funct_e f, input lsu_bytes_e b,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int gw, input int rw,
                           input bit spur, input bit scr,
                           input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] eld);
    int busy_n;
    logic [31:0] eaddr;
    eaddr = {a[31:2], 2'b00};
    // IDLE, request presented
    @(negedge clk);
    en = 1'b1; funct = f; bytes = b; addr = a; st_data = sd;
    mem_gnt = 1'b0; mem_rvalid = spur; mem_rdata = JUNK;
    #1;
    chk("idle_busy", {31'b0, busy}, 32'd1);
    chk("idle_mis", {30'b0, mis_ld, mis_st}, 32'd0);
    chk("idle_req", {31'b0, mem_req}, 32'd0);
    busy_n = busy ? 1 : 0;
    // REQ, with gw grant wait cycles
    for (int i = 0; i <= gw; i++) begin
      @(negedge clk);
      if (scr) scramble_inputs();
      mem_gnt = (i == gw); mem_rvalid = spur; mem_rdata = JUNK;
      #1;
      chk("req_req", {31'b0, mem_req}, 32'd1);
      chk("req_we", {31'b0, mem_we}, {31'b0, f == LSU_STORE});
      chk("req_addr", mem_addr, eaddr);
      chk("req_be", {28'b0, mem_be}, {28'b0, ebe});
      chk("req_wdata", mem_wdata, ewd);
      if (busy) busy_n++;
    end
    // RESP, with rw response wait cycles
    for (int i = 0; i <= rw; i++) begin
      @(negedge clk);
      if (scr) scramble_inputs();
      mem_gnt = 1'b0; mem_rvalid = (i == rw); mem_rdata = (i == rw) ? rd : JUNK;
      #1;
      chk("resp_req", {31'b0, mem_req}, 32'd0);
      if (busy) busy_n++;
    end
    // DONE
    @(negedge clk);
    if (scr) scramble_inputs();
    mem_gnt = 1'b0; mem_rvalid = spur; mem_rdata = JUNK;
    #1;
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_mis", {30'b0, mis_ld, mis_st}, 32'd0);
    chk("done_req", {31'b0, mem_req}, 32'd0);
    chk("done_ld_data", ld_data, eld);
    chk("busy_cycles", busy_n, 3 + gw + rw);
  endtask

  // A misaligned request: flag raised, no stall, no bus activity.
  task automatic do_mis(input lsu_funct_e f, input lsu_bytes_e b,
                        input logic [31:0] a, input logic [31:0] eld);
    @(negedge clk);
    en = 1'b1; funct = f; bytes = b; addr = a; st_data = $urandom;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = JUNK;
    #1;
    chk("mis_ld", {31'b0, mis_ld}, {31'b0, f == LSU_LOAD});
    chk("mis_st", {31'b0, mis_st}, {31'b0, f == LSU_STORE});
    chk("mis_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("mis_req", {31'b0, mem_req}, 32'd0);
      chk("mis_busy_hold", {31'b0, busy}, 32'd0);
    end
    chk("mis_ld_data", ld_data, eld);
    en = 1'b0;
  endtask

  typedef struct {
    lsu_funct_e  f;
    lsu_bytes_e  b;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          gw;
    int          rw;
    bit          spur;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst = 1'b1; en = 1'b0; funct = LSU_LOAD; bytes = LSU_B; addr = 32'h0;
    st_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    tbl[0]  = '{LSU_LOAD,  LSU_B,  32'h0000_1002, 32'h0,         32'h1280_5678, 0, 0, 1'b0, 1'b0, 4'b0100, 32'h0,         32'hFFFF_FF80};
    tbl[1]  = '{LSU_STORE, LSU_B,  32'h0000_2003, 32'h0000_00AB, 32'h0,         2, 0, 1'b0, 1'b0, 4'b1000, 32'hAB00_0000, 32'hFFFF_FF80};
    tbl[2]  = '{LSU_LOAD,  LSU_W,  32'h0000_1001, 32'h0,         32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80};
    tbl[3]  = '{LSU_LOAD,  LSU_HU, 32'h0000_0002, 32'h0,         32'hBEEF_1234, 0, 0, 1'b0, 1'b0, 4'b1100, 32'h0,         32'h0000_BEEF};
    tbl[4]  = '{LSU_LOAD,  LSU_H,  32'h0000_0000, 32'h0,         32'h0000_F00D, 0, 1, 1'b0, 1'b0, 4'b0011, 32'h0,         32'hFFFF_F00D};
    tbl[5]  = '{LSU_STORE, LSU_H,  32'h0000_0003, 32'h0,         32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_F00D};
    tbl[6]  = '{LSU_STORE, LSU_W,  32'h0000_0010, 32'hCAFE_F00D, 32'h0,         0, 0, 1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_F00D};
    tbl[7]  = '{LSU_LOAD,  LSU_W,  32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1, 2, 1'b1, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D};
    tbl[8]  = '{LSU_LOAD,  LSU_BU, 32'h0000_0001, 32'h0,         32'h0000_9A00, 0, 0, 1'b0, 1'b0, 4'b0010, 32'h0,         32'h0000_009A};
    tbl[9]  = '{LSU_STORE, LSU_H,  32'h0000_0002, 32'h1234_ABCD, 32'h0,         0, 0, 1'b0, 1'b0, 4'b1100, 32'hABCD_0000, 32'h0000_009A};
    tbl[10] = '{LSU_LOAD,  LSU_H,  32'h0000_0001, 32'h0,         32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0000_009A};
    tbl[11] = '{LSU_LOAD,  LSU_B,  32'h0000_0003, 32'h0,         32'h7F00_0000, 0, 1, 1'b0, 1'b0, 4'b1000, 32'h0,         32'h0000_007F};
    tbl[12] = '{LSU_STORE, LSU_W,  32'h0000_0002, 32'h0,         32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0000_007F};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, applied back to back
    foreach (tbl[i]) begin
      if (tbl[i].mis)
        do_mis(tbl[i].f, tbl[i].b, tbl[i].a, tbl[i].ld);
      else
        do_access(tbl[i].f, tbl[i].b, tbl[i].a, tbl[i].sd, tbl[i].rd, tbl[i].gw,
                  tbl[i].rw, tbl[i].spur, 1'b0, tbl[i].be, tbl[i].wd, tbl[i].ld);
    end

    // Reset asserted while waiting for a response, then a stale response
    @(negedge clk);
    en = 1'b1; funct = LSU_LOAD; bytes = LSU_W; addr = 32'h0000_0020;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("rr_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1; en = 1'b0;
    #1;
    chk("rr_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rr_ld_clear", ld_data, 32'h0);
    chk("rr_addr_clear", mem_addr, 32'h0);
    chk("rr_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("rr_stale_ld", ld_data, 32'h0);
    chk("rr_stale_req", {31'b0, mem_req}, 32'd0);
    chk("rr_stale_busy", {31'b0, busy}, 32'd0);
    exp_ld = 32'h0;

    // Randomized accesses against the model
    for (int n = 0; n < 200; n++) begin
      lsu_funct_e  f;
      lsu_bytes_e  b;
      logic [31:0] a, sd, rd;
      f  = lsu_funct_e'($urandom_range(0, 1));
      b  = (f == LSU_STORE) ? lsu_bytes_e'($urandom_range(0, 2))
                            : lsu_bytes_e'($urandom_range(0, 4));
      a  = $urandom;
      sd = $urandom;
      rd = $urandom;
      if (m_mis(b, a)) begin
        do_mis(f, b, a, exp_ld);
      end else begin
        if (f == LSU_LOAD) exp_ld = m_load(b, a, rd);
        do_access(f, b, a, sd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b1, m_be(b, a), m_wdata(sd, a), exp_ld);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
